// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad front end: matrix geometry, key index
// type, (row, col) -> index mapping and the lowest-set-bit encoder for key_code.
package keypad_pkg;

    localparam int ROWS = 4;
    localparam int COLS = 4;

    typedef logic [3:0] key_idx_t;

    function automatic key_idx_t key_index(input logic [1:0] r, input logic [1:0] c);
        return {r, c};
    endfunction

    // Lowest index wins so simultaneous presses report a deterministic code.
    function automatic key_idx_t lowest_set(input logic [15:0] v);
        key_idx_t idx;
        idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) begin
                idx = 4'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scan_key_debounce.sv
// Single-key debouncer: saturating change counter plus level register, advanced
// only on the key's row sample. rise_o is combinational and is registered by the top.
module key_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sample_en_i,
    input  logic raw_i,
    output logic level_o,
    output logic rise_o
);

    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_SCANS - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;

    // Next-state: clear on agreement, count on disagreement, flip on the Nth miss.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_o  = 1'b0;
        if (sample_en_i) begin
            if (raw_i == level_q) begin
                cnt_d = {CW{1'b0}};
            end else if (cnt_q >= CNT_LAST) begin
                cnt_d   = {CW{1'b0}};
                level_d = ~level_q;
                rise_o  = ~level_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q   <= {CW{1'b0}};
            level_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner with per-key debounce and press events.
// Optional auto-repeat is built when KEYPAD_AUTOREPEAT_EN is defined.
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 50_000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int REPEAT_DELAY   = 50,
    parameter int REPEAT_RATE    = 10
) (
    input  logic        clkin,
    input  logic        reset_n,
    input  logic [3:0]  col,
    output logic [3:0]  row,
    output logic [15:0] key_level,
    output logic [15:0] key_press,
    output logic        key_valid,
    output logic [3:0]  key_code
);

    if (SCAN_DIV < 4 || DEBOUNCE_SCANS < 1 || REPEAT_RATE < 1 || REPEAT_RATE > REPEAT_DELAY) begin : g_bad_param
        $error("keypad_scan: illegal parameter set");
    end

    localparam int DW = $clog2(SCAN_DIV);

    logic [DW-1:0] dwell_q, dwell_d;
    logic [1:0]    row_idx_q, row_idx_d;
    logic [3:0]    row_q, row_d;
    logic [3:0]    col_meta_q, col_sync_q;
    logic          sample_s;
    logic [15:0]   level_s, rise_s, rep_s, press_d;
    logic [15:0]   key_press_q;
    logic          key_valid_q;
    key_idx_t      key_code_q;

    assign sample_s = (dwell_q == DW'(SCAN_DIV - 1));

    // Row dwell counter and one-hot-low row rotation.
    always_comb begin
        dwell_d   = dwell_q;
        row_idx_d = row_idx_q;
        row_d     = row_q;
        if (sample_s) begin
            dwell_d   = {DW{1'b0}};
            row_idx_d = row_idx_q + 2'd1;
            row_d     = {row_q[2:0], row_q[3]};
        end else begin
            dwell_d = dwell_q + DW'(1);
        end
    end

    // Scan registers plus 2-FF column synchroniser (idle columns read high).
    always_ff @(posedge clkin or negedge reset_n) begin
        if (!reset_n) begin
            dwell_q    <= {DW{1'b0}};
            row_idx_q  <= 2'd0;
            row_q      <= 4'b1110;
            col_meta_q <= 4'hF;
            col_sync_q <= 4'hF;
        end else begin
            dwell_q    <= dwell_d;
            row_idx_q  <= row_idx_d;
            row_q      <= row_d;
            col_meta_q <= col;
            col_sync_q <= col_meta_q;
        end
    end

    for (genvar gr = 0; gr < ROWS; gr++) begin : g_row
        for (genvar gc = 0; gc < COLS; gc++) begin : g_col
            localparam int K = int'(key_index(2'(gr), 2'(gc)));
            logic en_s, raw_s;

            assign en_s  = sample_s && (row_idx_q == 2'(gr));
            assign raw_s = ~col_sync_q[gc];

            key_debounce #(.DEBOUNCE_SCANS(DEBOUNCE_SCANS)) u_deb (
                .clk_i       (clkin),
                .rst_ni      (reset_n),
                .sample_en_i (en_s),
                .raw_i       (raw_s),
                .level_o     (level_s[K]),
                .rise_o      (rise_s[K])
            );
`ifdef KEYPAD_AUTOREPEAT_EN
            localparam int RW = $clog2(REPEAT_DELAY + 1);
            logic [RW-1:0] rep_q, rep_d;
            logic          rep_hit_s;

            // A released-but-not-yet-debounced key (raw low) never repeats.
            assign rep_hit_s = en_s && level_s[K] && raw_s && (rep_q == RW'(REPEAT_DELAY - 1));

            // Held-frame counter; reloads so later repeats come every REPEAT_RATE frames.
            always_comb begin
                rep_d = rep_q;
                if (!level_s[K]) begin
                    rep_d = {RW{1'b0}};
                end else if (en_s) begin
                    if (rep_q == RW'(REPEAT_DELAY - 1)) begin
                        rep_d = RW'(REPEAT_DELAY - REPEAT_RATE);
                    end else begin
                        rep_d = rep_q + RW'(1);
                    end
                end else begin
                    rep_d = rep_q;
                end
            end

            // Repeat counter register.
            always_ff @(posedge clkin or negedge reset_n) begin
                if (!reset_n) begin
                    rep_q <= {RW{1'b0}};
                end else begin
                    rep_q <= rep_d;
                end
            end

            assign rep_s[K] = rep_hit_s;
`else
            assign rep_s[K] = 1'b0;
`endif
        end
    end

    assign press_d = rise_s | rep_s;

    // Registered event outputs.
    always_ff @(posedge clkin or negedge reset_n) begin
        if (!reset_n) begin
            key_press_q <= 16'h0000;
            key_valid_q <= 1'b0;
            key_code_q  <= 4'd0;
        end else begin
            key_press_q <= press_d;
            key_valid_q <= |press_d;
            key_code_q  <= lowest_set(press_d);
        end
    end

    assign row       = row_q;
    assign key_level = level_s;
    assign key_press = key_press_q;
    assign key_valid = key_valid_q;
    assign key_code  = key_code_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan (SCAN_DIV=4, DEBOUNCE_SCANS=3, 16-cycle frame);
// expectations follow KEYPAD_AUTOREPEAT_EN when it is defined.
module tb_keypad_scan;

    logic        clkin = 1'b0;
    logic        reset_n;
    logic [3:0]  col;
    logic [3:0]  row;
    logic [15:0] key_level;
    logic [15:0] key_press;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [15:0] keys;

    keypad_scan #(
        .SCAN_DIV       (4),
        .DEBOUNCE_SCANS (3),
        .REPEAT_DELAY   (8),
        .REPEAT_RATE    (2)
    ) dut (
        .clkin     (clkin),
        .reset_n   (reset_n),
        .col       (col),
        .row       (row),
        .key_level (key_level),
        .key_press (key_press),
        .key_valid (key_valid),
        .key_code  (key_code)
    );

    always #5 clkin = ~clkin;

    // Keypad model: a held key pulls its column low while its row is driven low.
    always_comb begin
        col = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4 + c] && !row[r]) begin
                    col[c] = 1'b0;
                end
            end
        end
    end

    typedef struct {
        logic [15:0] keys;
        int          ncyc;
        logic [15:0] exp_level;
        logic [15:0] exp_or;
        int          exp_pulses;
        logic [3:0]  exp_code;
    } vec_t;

    vec_t vecs[15];
    int   total;
    int   bad;
    int   cyc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cyc %0d: got %0h want %0h", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clkin);
        #1;
        cyc++;
    endtask

    task automatic setv(input int i, input logic [15:0] k, input int n, input logic [15:0] lvl,
                        input logic [15:0] orv, input int np, input logic [3:0] code);
        vecs[i].keys       = k;
        vecs[i].ncyc       = n;
        vecs[i].exp_level  = lvl;
        vecs[i].exp_or     = orv;
        vecs[i].exp_pulses = np;
        vecs[i].exp_code   = code;
    endtask

    // Runs to cycle 'last'; exactly one event 'pv' is expected at cycle 'at'.
    task automatic press_window(input int last, input int at, input logic [15:0] pv, input logic [3:0] code);
        while (cyc < last) begin
            tick();
            chk("press", key_press, (cyc == at) ? pv : 16'h0000);
            chk("valid", key_valid, (cyc == at) ? 1'b1 : 1'b0);
            chk("level", key_level, (cyc >= at) ? pv : 16'h0000);
            if (cyc == at) begin
                chk("code", key_code, code);
            end
        end
    endtask

    initial begin
        int          rep_pulses;
        int          pulses;
        logic [15:0] orv;
        logic [3:0]  lc;
        logic [3:0]  exp_row;

        keys    = 16'h0000;
        reset_n = 1'b0;
        total   = 0;
        bad     = 0;
        cyc     = 0;
`ifdef KEYPAD_AUTOREPEAT_EN
        rep_pulses = 4;
`else
        rep_pulses = 1;
`endif
        setv(0,  16'h0000, 64,  16'h0000, 16'h0000, 0, 4'd0);
        setv(1,  16'h0050, 64,  16'h0050, 16'h0050, 1, 4'd4);
        setv(2,  16'h0000, 64,  16'h0000, 16'h0000, 0, 4'd0);
        setv(3,  16'h8001, 64,  16'h8001, 16'h8001, 2, 4'd15);
        setv(4,  16'h0000, 64,  16'h0000, 16'h0000, 0, 4'd0);
        setv(5,  16'h0404, 64,  16'h0404, 16'h0404, 2, 4'd10);
        setv(6,  16'h0000, 64,  16'h0000, 16'h0000, 0, 4'd0);
        for (int b = 0; b < 3; b++) begin
            setv(7 + 2*b, 16'h0200, 32, 16'h0000, 16'h0000, 0, 4'd0);
            setv(8 + 2*b, 16'h0000, 16, 16'h0000, 16'h0000, 0, 4'd0);
        end
        setv(13, 16'h0001, 256, 16'h0001, 16'h0001, rep_pulses, 4'd0);
        setv(14, 16'h0000, 64,  16'h0000, 16'h0000, 0, 4'd0);

        // Reset state.
        repeat (3) @(posedge clkin);
        #1;
        chk("rst_row", row, 4'b1110);
        chk("rst_level", key_level, 16'h0000);
        chk("rst_press", key_press, 16'h0000);
        chk("rst_valid", key_valid, 1'b0);
        chk("rst_code", key_code, 4'd0);

        // Idle scan after reset release.
        @(negedge clkin);
        reset_n = 1'b1;
        cyc     = 0;
        for (int i = 0; i < 16; i++) begin
            if (i > 0) begin
                tick();
            end
            exp_row = 4'b0001 << ((i / 4) % 4);
            exp_row = ~exp_row;
            chk("idle_row", row, exp_row);
            chk("idle_valid", key_valid, 1'b0);
        end

        // Single press of key 5: first row-1 sample at cycle 23, event at 23+32+1.
        tick();
        keys = 16'h0020;
        press_window(128, 56, 16'h0020, 4'd5);

        // Frame-aligned vector table.
        for (int v = 0; v < 15; v++) begin
            keys   = vecs[v].keys;
            pulses = 0;
            orv    = 16'h0000;
            lc     = 4'd0;
            for (int k = 0; k < vecs[v].ncyc; k++) begin
                tick();
                if (key_valid) begin
                    pulses++;
                    orv = orv | key_press;
                    lc  = key_code;
                end
            end
            chk($sformatf("vec%0d_level", v), key_level, vecs[v].exp_level);
            chk($sformatf("vec%0d_press_or", v), orv, vecs[v].exp_or);
            chk($sformatf("vec%0d_pulses", v), pulses, vecs[v].exp_pulses);
            chk($sformatf("vec%0d_code", v), lc, vecs[v].exp_code);
        end

        // Reset while key 5 is held, then re-acceptance with a fresh event.
        keys = 16'h0020;
        repeat (64) tick();
        chk("held_level", key_level, 16'h0020);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_level", key_level, 16'h0000);
        chk("mid_rst_press", key_press, 16'h0000);
        chk("mid_rst_valid", key_valid, 1'b0);
        chk("mid_rst_code", key_code, 4'd0);
        chk("mid_rst_row", row, 4'b1110);
        repeat (3) tick();
        chk("mid_rst_level_hold", key_level, 16'h0000);
        reset_n = 1'b1;
        cyc     = 0;
        press_window(64, 40, 16'h0020, 4'd5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
